// File: rtl/md_issue_ctrl.sv
// Multiply/divide issue control: decodes E-stage MD ops, fires start/HiLo-write the same cycle, and tracks MD occupancy with a local countdown.
// Zero-cycle issue; a held E instruction fires once; MD-class ops in D stall while the unit is (or is about to be) busy.
module md_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    input  logic [31:0] instr_E,
    input  logic        valid_E,
    input  logic        hold_E,
    input  logic        flush_E,
    input  logic        md_stall,
    output logic        md_start,
    output logic [1:0]  md_hilowr,
    output logic [31:0] md_instr,
    output logic        stall_D,
    output logic        busy,
    output logic        md_err
);

    // SPECIAL opcode (000000) with funct 0110xx = start, 0100xx = HI/LO move.
    localparam logic [31:0] DEC_MASK   = 32'hFC00_003C;
    localparam logic [31:0] DEC_START  = 32'h0000_0018;
    localparam logic [31:0] DEC_HILO   = 32'h0000_0010;
    localparam logic [3:0]  MUL_LOAD   = 4'(MUL_CYCLES);
    localparam logic [3:0]  DIV_LOAD   = 4'(DIV_CYCLES);

    logic [3:0] cnt;
    logic       issued;
    logic       start_q;
    logic       idle_stall_q;

    logic       start_e;
    logic       hilo_e;
    logic       write_e;
    logic       md_class_d;
    logic       issue_ok;
    logic       idle_stall;

    always_comb begin
        start_e    = (instr_E & DEC_MASK) == DEC_START;
        hilo_e     = (instr_E & DEC_MASK) == DEC_HILO;
        write_e    = hilo_e & instr_E[0];
        md_class_d = ((instr_D & DEC_MASK) == DEC_START) | ((instr_D & DEC_MASK) == DEC_HILO);
        issue_ok   = valid_E & ~flush_E & ~issued & (cnt == 4'd0);
    end

    assign md_start  = issue_ok & start_e;
    // funct bit 1 separates mtlo (010011) from mthi (010001).
    assign md_hilowr = (issue_ok & write_e) ? {instr_E[1], ~instr_E[1]} : 2'b00;
    assign md_instr  = instr_E;
    assign busy      = (cnt != 4'd0);
    // MD's own busy flag lags by a cycle, so the start cycle must stall D here.
    assign stall_D   = md_class_d & (busy | md_start | (md_hilowr != 2'b00) |
                                     (valid_E & start_e & ~flush_E));
    assign idle_stall = (cnt == 4'd0) & md_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= 4'd0;
            issued       <= 1'b0;
            start_q      <= 1'b0;
            idle_stall_q <= 1'b0;
            md_err       <= 1'b0;
        end else begin
            if (md_start)
                cnt <= instr_E[1] ? DIV_LOAD : MUL_LOAD;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;

            issued       <= hold_E & (issued | md_start | (md_hilowr != 2'b00));
            start_q      <= md_start;
            idle_stall_q <= idle_stall;

            // The edge right after a start is exempt: MD raises its busy one cycle late.
            if (((cnt > 4'd1) & ~md_stall & ~start_q) | (idle_stall & idle_stall_q))
                md_err <= 1'b1;
        end
    end

endmodule
